// File: rtl/fb_rxstatem_param.sv
// Receive-side frame state machine for the FreeDM nibble bus: preamble/SOC detection,
// multi-beat payload byte counting and CRC beat counting. Optional macro FB_RXSM_DROP_EN adds DROP.
module fb_rxstatem_param #(
  parameter int unsigned DW        = 4,
  parameter int unsigned BEATS     = 2,
  parameter int unsigned NUM_TYPES = 4,
  parameter logic [DW-1:0] PRE_CODE = 4'h5,
  parameter logic [NUM_TYPES*DW-1:0] SOC_CODES = {4'h7, 4'h9, 4'hB, 4'hD},
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned CRC_BEATS = 8,
  parameter int unsigned MAX_BYTES = 200,
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                       MRxClk,
  input  logic                       Reset,
  input  logic                       MRxDV,
  input  logic [DW-1:0]              MRxD,
  input  logic [NUM_TYPES*CNT_W-1:0] TypeLen,
  input  logic                       FrameEnd,
  output logic                       StateIdle,
  output logic                       StateFFS,
  output logic                       StatePreamble,
  output logic                       StatePayload,
  output logic                       StateFrmCrc,
  output logic                       StateDrop,
  output logic [BW-1:0]              BeatCnt,
  output logic [NUM_TYPES-1:0]       FrameType,
  output logic [CNT_W-1:0]           ByteCnt,
  output logic                       FrameDone,
  output logic                       FrameAbort
);

  localparam int unsigned CW = (CRC_BEATS > 1) ? $clog2(CRC_BEATS) : 1;

  if (MAX_BYTES >= (1 << CNT_W)) begin : g_max_bytes_check
    $error("MAX_BYTES must be below 2**CNT_W");
  end

  typedef enum logic [2:0] {S_IDLE, S_FFS, S_PRE, S_PAY, S_CRC, S_DROP} state_t;

  state_t               state, stateNxt;
  logic [CW-1:0]        crcCnt, crcCntNxt;
  logic [BW-1:0]        beatNxt;
  logic [CNT_W-1:0]     byteNxt, curLen;
  logic [CNT_W:0]       byteInc;
  logic [NUM_TYPES-1:0] typeNxt, socType;
  logic                 socHit, isPre, beatLast, crcLast, lenHit, varEnd, dropHit;
  logic                 doneNxt, abortNxt;

  // SOC decode; descending scan so the lowest matching type wins
  always_comb begin
    socHit  = 1'b0;
    socType = '0;
    for (int k = int'(NUM_TYPES) - 1; k >= 0; k--) begin
      if (MRxD == SOC_CODES[k*DW +: DW]) begin
        socHit     = 1'b1;
        socType    = '0;
        socType[k] = 1'b1;
      end
    end
  end

  // Length of the latched frame type
  always_comb begin
    curLen = '0;
    for (int k = 0; k < int'(NUM_TYPES); k++) begin
      if (FrameType[k]) curLen |= TypeLen[k*CNT_W +: CNT_W];
    end
  end

  assign isPre    = (MRxD == PRE_CODE);
  assign beatLast = (BeatCnt == BW'(BEATS - 1));
  assign crcLast  = (crcCnt == CW'(CRC_BEATS - 1));
  assign byteInc  = {1'b0, ByteCnt} + (CNT_W+1)'(1);
  assign lenHit   = (curLen != '0) && (byteInc == {1'b0, curLen});
  assign varEnd   = (curLen == '0) && FrameEnd;
`ifdef FB_RXSM_DROP_EN
  assign dropHit  = (curLen == '0) && !FrameEnd && (byteInc == (CNT_W+1)'(MAX_BYTES));
`else
  assign dropHit  = 1'b0;
`endif

  always_ff @(posedge MRxClk) begin
    if (Reset) state <= S_IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      S_IDLE:  if (MRxDV) stateNxt = isPre ? S_PRE : S_FFS;
      S_FFS:   if (!MRxDV) stateNxt = S_IDLE;
               else if (isPre) stateNxt = S_PRE;
      S_PRE:   if (!MRxDV) stateNxt = S_IDLE;
               else if (isPre) stateNxt = S_PRE;
               else if (socHit) stateNxt = S_PAY;
               else stateNxt = S_FFS;
      S_PAY:   if (!MRxDV) stateNxt = S_IDLE;
               else if (beatLast) begin
                 if (lenHit || varEnd) stateNxt = S_CRC;
                 else if (dropHit)     stateNxt = S_DROP;
               end
      S_CRC:   if (!MRxDV || crcLast) stateNxt = S_IDLE;
      S_DROP:  if (!MRxDV) stateNxt = S_IDLE;
      default: stateNxt = S_IDLE;
    endcase
  end

  // Counter, type and pulse next values
  always_comb begin
    beatNxt   = BeatCnt;
    byteNxt   = ByteCnt;
    typeNxt   = FrameType;
    crcCntNxt = crcCnt;
    doneNxt   = 1'b0;
    abortNxt  = 1'b0;
    unique case (state)
      S_PRE: if (MRxDV && !isPre && socHit) begin
        typeNxt = socType;
        byteNxt = '0;
        beatNxt = '0;
      end
      S_PAY: begin
        crcCntNxt = '0;
        if (!MRxDV) abortNxt = 1'b1;
        else begin
          beatNxt = beatLast ? '0 : BeatCnt + BW'(1);
          if (beatLast) begin
            if (!byteInc[CNT_W]) byteNxt = byteInc[CNT_W-1:0];
            if (dropHit && !(lenHit || varEnd)) abortNxt = 1'b1;
          end
        end
      end
      S_CRC: begin
        if (!MRxDV)       abortNxt  = 1'b1;
        else if (crcLast) doneNxt   = 1'b1;
        else              crcCntNxt = crcCnt + CW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge MRxClk) begin
    if (Reset) begin
      StateIdle     <= 1'b1;
      StateFFS      <= 1'b0;
      StatePreamble <= 1'b0;
      StatePayload  <= 1'b0;
      StateFrmCrc   <= 1'b0;
`ifdef FB_RXSM_DROP_EN
      StateDrop     <= 1'b0;
`endif
      BeatCnt       <= '0;
      ByteCnt       <= '0;
      FrameType     <= '0;
      crcCnt        <= '0;
      FrameDone     <= 1'b0;
      FrameAbort    <= 1'b0;
    end else begin
      StateIdle     <= (stateNxt == S_IDLE);
      StateFFS      <= (stateNxt == S_FFS);
      StatePreamble <= (stateNxt == S_PRE);
      StatePayload  <= (stateNxt == S_PAY);
      StateFrmCrc   <= (stateNxt == S_CRC);
`ifdef FB_RXSM_DROP_EN
      StateDrop     <= (stateNxt == S_DROP);
`endif
      BeatCnt       <= beatNxt;
      ByteCnt       <= byteNxt;
      FrameType     <= typeNxt;
      crcCnt        <= crcCntNxt;
      FrameDone     <= doneNxt;
      FrameAbort    <= abortNxt;
    end
  end

`ifndef FB_RXSM_DROP_EN
  assign StateDrop = 1'b0;
`endif

endmodule

// File: tb/tb_fb_rxstatem_param.sv
// Directed bench for fb_rxstatem_param with default parameters; DROP expectations follow FB_RXSM_DROP_EN.
module tb_fb_rxstatem_param;

  localparam logic [5:0] F_IDLE = 6'b100000;
  localparam logic [5:0] F_FFS  = 6'b010000;
  localparam logic [5:0] F_PRE  = 6'b001000;
  localparam logic [5:0] F_PAY  = 6'b000100;
  localparam logic [5:0] F_CRC  = 6'b000010;
  localparam logic [5:0] F_DROP = 6'b000001;

  logic        MRxClk = 1'b0;
  logic        Reset = 1'b1;
  logic        MRxDV = 1'b0;
  logic [3:0]  MRxD = 4'h0;
  logic [31:0] TypeLen = 32'h0;
  logic        FrameEnd = 1'b0;
  logic        StateIdle, StateFFS, StatePreamble, StatePayload, StateFrmCrc, StateDrop;
  logic [0:0]  BeatCnt;
  logic [3:0]  FrameType;
  logic [7:0]  ByteCnt;
  logic        FrameDone, FrameAbort;
  logic [5:0]  flags;
  logic [1:0]  pulses;
  int          assertions = 0;
  int          failures = 0;

  assign flags  = {StateIdle, StateFFS, StatePreamble, StatePayload, StateFrmCrc, StateDrop};
  assign pulses = {FrameDone, FrameAbort};

  always #5 MRxClk = ~MRxClk;

  fb_rxstatem_param dut (
    .MRxClk(MRxClk), .Reset(Reset), .MRxDV(MRxDV), .MRxD(MRxD), .TypeLen(TypeLen),
    .FrameEnd(FrameEnd), .StateIdle(StateIdle), .StateFFS(StateFFS),
    .StatePreamble(StatePreamble), .StatePayload(StatePayload), .StateFrmCrc(StateFrmCrc),
    .StateDrop(StateDrop), .BeatCnt(BeatCnt), .FrameType(FrameType), .ByteCnt(ByteCnt),
    .FrameDone(FrameDone), .FrameAbort(FrameAbort)
  );

  // One beat; outputs are sampled 1 time unit after the edge that consumed it
  task automatic drive(input logic dv, input logic [3:0] d, input logic fe);
    MRxDV = dv; MRxD = d; FrameEnd = fe;
    @(posedge MRxClk); #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if (flags !== F_IDLE) begin failures++; $display("FAIL reset_flags: got %b want %b", flags, F_IDLE); end
    assertions++; if ({BeatCnt, FrameType, ByteCnt} !== 13'd0) begin failures++; $display("FAIL reset_counts: got %h want 0", {BeatCnt, FrameType, ByteCnt}); end
    assertions++; if (pulses !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", pulses); end
    Reset = 1'b0;
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    drive(1'b1, 4'h3, 1'b0);
    assertions++; if ({flags, ByteCnt, BeatCnt} !== {F_PAY, 8'd1, 1'b1}) begin failures++; $display("FAIL midframe_setup: got %b/%0d/%0d want %b/1/1", flags, ByteCnt, BeatCnt, F_PAY); end
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'h3, 1'b0);
      assertions++; if (pulses !== 2'b00) begin failures++; $display("FAIL midframe_reset_pulse%0d: got %b want 00", i, pulses); end
    end
    Reset = 1'b0;
    assertions++; if (flags !== F_IDLE) begin failures++; $display("FAIL midframe_reset_flags: got %b want %b", flags, F_IDLE); end
    assertions++; if ({FrameType, ByteCnt} !== 12'd0) begin failures++; $display("FAIL midframe_reset_counts: got %h want 0", {FrameType, ByteCnt}); end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses} !== {F_IDLE, 2'b00}) begin failures++; $display("FAIL after_reset_release: got %b want %b", {flags, pulses}, {F_IDLE, 2'b00}); end
  endtask

  task automatic run_fixed_type1;
    drive(1'b1, 4'h5, 1'b0);
    assertions++; if (flags !== F_PRE) begin failures++; $display("FAIL fixed_pre: got %b want %b", flags, F_PRE); end
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hB, 1'b0);
    assertions++; if ({flags, FrameType, ByteCnt, BeatCnt} !== {F_PAY, 4'b0010, 8'd0, 1'b0}) begin failures++; $display("FAIL fixed_soc: got %b/%b/%0d/%0d want %b/0010/0/0", flags, FrameType, ByteCnt, BeatCnt, F_PAY); end
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(i), 1'b0);
    assertions++; if ({flags, ByteCnt, BeatCnt} !== {F_PAY, 8'd2, 1'b1}) begin failures++; $display("FAIL fixed_beat5: got %b/%0d/%0d want %b/2/1", flags, ByteCnt, BeatCnt, F_PAY); end
    drive(1'b1, 4'hF, 1'b0);
    assertions++; if ({flags, ByteCnt} !== {F_CRC, 8'd3}) begin failures++; $display("FAIL fixed_crc_entry: got %b/%0d want %b/3", flags, ByteCnt, F_CRC); end
    for (int i = 0; i < 7; i++) drive(1'b1, 4'hA, 1'b0);
    assertions++; if ({flags, pulses} !== {F_CRC, 2'b00}) begin failures++; $display("FAIL fixed_crc7: got %b want %b", {flags, pulses}, {F_CRC, 2'b00}); end
    drive(1'b1, 4'hA, 1'b0);
    assertions++; if ({flags, pulses, ByteCnt, FrameType} !== {F_IDLE, 2'b10, 8'd3, 4'b0010}) begin failures++; $display("FAIL fixed_done: got %b/%b/%0d/%b want %b/10/3/0010", flags, pulses, ByteCnt, FrameType, F_IDLE); end
  endtask

  task automatic test_fixed_length;
    TypeLen = 32'h0000_0300;
    run_fixed_type1();
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses, ByteCnt} !== {F_IDLE, 2'b00, 8'd3}) begin failures++; $display("FAIL fixed_hold: got %b/%b/%0d want %b/00/3", flags, pulses, ByteCnt, F_IDLE); end
  endtask

  task automatic test_ffs;
    drive(1'b1, 4'h3, 1'b0);
    assertions++; if ({flags, pulses} !== {F_FFS, 2'b00}) begin failures++; $display("FAIL ffs_enter: got %b want %b", {flags, pulses}, {F_FFS, 2'b00}); end
    drive(1'b1, 4'h5, 1'b0);
    assertions++; if ({flags, pulses} !== {F_PRE, 2'b00}) begin failures++; $display("FAIL ffs_to_pre: got %b want %b", {flags, pulses}, {F_PRE, 2'b00}); end
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    assertions++; if ({flags, pulses} !== {F_FFS, 2'b00}) begin failures++; $display("FAIL ffs_bad_soc: got %b want %b", {flags, pulses}, {F_FFS, 2'b00}); end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses} !== {F_IDLE, 2'b00}) begin failures++; $display("FAIL ffs_exit: got %b want %b", {flags, pulses}, {F_IDLE, 2'b00}); end
  endtask

  task automatic test_variable_length;
    TypeLen = 32'h0000_0300;
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    assertions++; if ({flags, FrameType} !== {F_PAY, 4'b0001}) begin failures++; $display("FAIL var_soc: got %b/%b want %b/0001", flags, FrameType, F_PAY); end
    for (int i = 0; i < 18; i++) drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h1, 1'b1);
    assertions++; if ({flags, ByteCnt} !== {F_PAY, 8'd9}) begin failures++; $display("FAIL var_fe_first_beat: got %b/%0d want %b/9", flags, ByteCnt, F_PAY); end
    drive(1'b1, 4'h1, 1'b1);
    assertions++; if ({flags, ByteCnt} !== {F_CRC, 8'd10}) begin failures++; $display("FAIL var_crc_entry: got %b/%0d want %b/10", flags, ByteCnt, F_CRC); end
    for (int i = 0; i < 4; i++) drive(1'b1, 4'hC, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses, ByteCnt} !== {F_IDLE, 2'b01, 8'd10}) begin failures++; $display("FAIL var_crc_abort: got %b/%b/%0d want %b/01/10", flags, pulses, ByteCnt, F_IDLE); end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if (pulses !== 2'b00) begin failures++; $display("FAIL var_abort_width: got %b want 00", pulses); end
  endtask

  task automatic test_early_abort;
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
    drive(1'b1, 4'h8, 1'b0);
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses, ByteCnt} !== {F_IDLE, 2'b01, 8'd0}) begin failures++; $display("FAIL early_abort: got %b/%b/%0d want %b/01/0", flags, pulses, ByteCnt, F_IDLE); end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if (pulses !== 2'b00) begin failures++; $display("FAIL early_abort_width: got %b want 00", pulses); end
  endtask

  task automatic test_back_to_back;
    TypeLen = 32'h0001_0300;
    run_fixed_type1();
    drive(1'b1, 4'h5, 1'b0);
    assertions++; if ({flags, pulses} !== {F_PRE, 2'b00}) begin failures++; $display("FAIL b2b_pre: got %b want %b", {flags, pulses}, {F_PRE, 2'b00}); end
    drive(1'b1, 4'h9, 1'b0);
    assertions++; if ({flags, FrameType, ByteCnt} !== {F_PAY, 4'b0100, 8'd0}) begin failures++; $display("FAIL b2b_type2: got %b/%b/%0d want %b/0100/0", flags, FrameType, ByteCnt, F_PAY); end
    drive(1'b1, 4'h1, 1'b0);
    drive(1'b1, 4'h2, 1'b0);
    assertions++; if ({flags, ByteCnt} !== {F_CRC, 8'd1}) begin failures++; $display("FAIL b2b_crc: got %b/%0d want %b/1", flags, ByteCnt, F_CRC); end
    for (int i = 0; i < 8; i++) drive(1'b1, 4'h0, 1'b0);
    assertions++; if ({flags, pulses} !== {F_IDLE, 2'b10}) begin failures++; $display("FAIL b2b_done: got %b want %b", {flags, pulses}, {F_IDLE, 2'b10}); end
    drive(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_long_frame;
    TypeLen = 32'h0000_0000;
    drive(1'b1, 4'h5, 1'b0);
    drive(1'b1, 4'hD, 1'b0);
`ifdef FB_RXSM_DROP_EN
    for (int j = 0; j < 400; j++) begin
      drive(1'b1, 4'h6, 1'b0);
      if (j == 398) begin
        assertions++; if ({flags, pulses, ByteCnt} !== {F_PAY, 2'b00, 8'd199}) begin failures++; $display("FAIL drop_before: got %b/%b/%0d want %b/00/199", flags, pulses, ByteCnt, F_PAY); end
      end
    end
    assertions++; if ({flags, pulses, ByteCnt} !== {F_DROP, 2'b01, 8'd200}) begin failures++; $display("FAIL drop_entry: got %b/%b/%0d want %b/01/200", flags, pulses, ByteCnt, F_DROP); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 4'h6, 1'b0);
      assertions++; if ({flags, pulses} !== {F_DROP, 2'b00}) begin failures++; $display("FAIL drop_hold%0d: got %b want %b", i, {flags, pulses}, {F_DROP, 2'b00}); end
    end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses} !== {F_IDLE, 2'b00}) begin failures++; $display("FAIL drop_exit: got %b want %b", {flags, pulses}, {F_IDLE, 2'b00}); end
`else
    for (int j = 0; j < 512; j++) begin
      drive(1'b1, 4'h6, 1'b0);
      if (j == 399) begin
        assertions++; if ({flags, pulses, ByteCnt} !== {F_PAY, 2'b00, 8'd200}) begin failures++; $display("FAIL long_200: got %b/%b/%0d want %b/00/200", flags, pulses, ByteCnt, F_PAY); end
      end
    end
    assertions++; if ({flags, ByteCnt} !== {F_PAY, 8'd255}) begin failures++; $display("FAIL long_saturate: got %b/%0d want %b/255", flags, ByteCnt, F_PAY); end
    drive(1'b0, 4'h0, 1'b0);
    assertions++; if ({flags, pulses, ByteCnt} !== {F_IDLE, 2'b01, 8'd255}) begin failures++; $display("FAIL long_abort: got %b/%b/%0d want %b/01/255", flags, pulses, ByteCnt, F_IDLE); end
`endif
  endtask

  initial begin
    test_reset();
    test_fixed_length();
    test_ffs();
    test_variable_length();
    test_early_abort();
    test_back_to_back();
    test_long_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/fb_rxstatem_param.md
# fb_rxstatem_param

Parametrised receive-side frame state machine for the FreeDM bus nibble interface. It sits between the MII-style receive pins (MRxDV/MRxD) and the receive data path. It detects preamble and the start-of-frame code for up to NUM_TYPES frame types, then walks the payload in multi-beat words and counts the trailing CRC itself. It reports a one-hot frame type, a byte count, and per-frame done/abort pulses.

## Interface
- DW, 4: width of MRxD in bits (one beat).
- BEATS, 2: beats per payload byte; power of two, 1..8.
- NUM_TYPES, 4: number of frame types recognised.
- PRE_CODE, 4'h5: preamble beat value.
- SOC_CODES, {4'h7,4'h9,4'hB,4'hD}: NUM_TYPES*DW bits; type k code is SOC_CODES[k*DW +: DW].
- CNT_W, 8: byte-counter width.
- CRC_BEATS, 8: beats in the CRC field, 1..255.
- MAX_BYTES, 200: payload byte limit for variable-length frames; must be < 2^CNT_W.
- MRxClk  in  1  receive clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- MRxDV  in  1  receive data valid.
- MRxD  in  DW  receive beat.
- TypeLen  in  NUM_TYPES*CNT_W  payload length in bytes per type; 0 means variable length.
- FrameEnd  in  1  end marker for variable-length frames; sampled only on the last beat of a byte.
- StateIdle, StateFFS, StatePreamble, StatePayload, StateFrmCrc, StateDrop  out  1 each  one-hot state flags.
- BeatCnt  out  $clog2(BEATS) (min 1)  beat index within the current byte.
- FrameType  out  NUM_TYPES  one-hot type of the current or last frame.
- ByteCnt  out  CNT_W  payload bytes completed.
- FrameDone  out  1  one-cycle pulse when a frame completes good.
- FrameAbort  out  1  one-cycle pulse when a frame is abandoned.

## Operation
- Reset values: StateIdle=1; all other state flags 0; BeatCnt=0, FrameType=0, ByteCnt=0, FrameDone=0, FrameAbort=0.
- **IDLE**
  - MRxDV & MRxD==PRE_CODE goes to PREAMBLE.
  - MRxDV with any other value goes to FFS.
- **FFS**
  - ~MRxDV goes to IDLE.
  - MRxD==PRE_CODE goes to PREAMBLE.
  - Otherwise stay.
- **PREAMBLE**
  - ~MRxDV goes to IDLE.
  - MRxD==PRE_CODE: stay.
  - MRxD==SOC code k goes to PAYLOAD with FrameType=1<<k. The lowest k wins on duplicate codes.
  - Any other value goes to FFS.
  - On entry to PAYLOAD: ByteCnt and BeatCnt are cleared.
- **PAYLOAD**
  - Each valid beat increments BeatCnt modulo BEATS.
  - On beat BEATS-1, ByteCnt increments.
  - Fixed length (len = TypeLen of latched type, nonzero): on beat BEATS-1 with ByteCnt+1==len, go to CRC.
  - Variable length: on beat BEATS-1 with FrameEnd=1, go to CRC.
  - ~MRxDV goes to IDLE with FrameAbort.
- **CRC**
  - An internal counter counts CRC_BEATS valid beats.
  - After the last beat: go to IDLE with FrameDone.
  - ~MRxDV before the last beat goes to IDLE with FrameAbort.
- ByteCnt and FrameType hold through CRC and IDLE until the next PAYLOAD entry.
- TypeLen is sampled every byte boundary; software changes it only while StateIdle=1.
- Reset asserted mid-frame returns to reset values on the next edge; no FrameAbort is generated.

## Timing
- All state flags are registered; a transition is visible one cycle after the qualifying beat.
- SOC beat at edge n gives StatePayload=1 and FrameType valid after edge n.
- The beat after the SOC is payload beat 0.
- FrameDone and FrameAbort are registered and high for exactly the cycle in which StateIdle first returns to 1.
- They are never both high.
- Zero-cycle gaps are allowed: MRxDV high on the first IDLE cycle is evaluated normally.
- Minimum frame: one preamble beat, SOC, len*BEATS payload beats, then CRC_BEATS beats.

## Configuration
- FB_RXSM_DROP_EN defined:
  - A variable-length frame whose ByteCnt reaches MAX_BYTES without FrameEnd goes to DROP, with a FrameAbort pulse on entry.
  - DROP holds until ~MRxDV, then goes to IDLE with no second pulse.
- Not defined:
  - StateDrop is tied 0.
  - ByteCnt saturates at 2^CNT_W-1.
  - The frame continues until FrameEnd or ~MRxDV.

## Test plan
- Reset held 3 cycles mid-PAYLOAD, then released -> StateIdle=1, ByteCnt=0, FrameType=0, no FrameAbort.
- TypeLen[type1]=3; drive 5,5,5,B, then 6 payload beats, then 8 CRC beats, then MRxDV=0 -> FrameType=4'b0010, ByteCnt=3, FrameDone high one cycle after the 8th CRC beat.
- Drive 3,5,5,2 -> FFS, then PREAMBLE, then FFS (2 is not a SOC code); no pulses.
- Variable type0 (0xD): FrameEnd on the 2nd beat of byte 10 -> CRC entered, ByteCnt=10; MRxDV dropped after 4 CRC beats -> FrameAbort, no FrameDone.
- FB_RXSM_DROP_EN defined, type0 with FrameEnd never asserted -> StateDrop=1 and FrameAbort pulse when ByteCnt=200; MRxDV held 20 more beats, then dropped -> StateIdle=1 with no second pulse.
- MRxDV dropped on payload beat 1 of byte 0 -> StateIdle=1 with FrameAbort the following cycle, ByteCnt=0.
